// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: merges the writeback stage with a 2-entry in-order
// long-latency result FIFO. WB has priority, and a starvation counter forces the LL head through.
module rf_wr_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  output logic                  wb_ready,
  input  logic                  ll_valid,
  input  logic [4:0]            ll_waddr,
  input  logic [DATA_WIDTH-1:0] ll_wdata,
  output logic                  ll_ready,
  output logic                  rf_wen,
  output logic [4:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [31:0]           ll_busy_mask
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [4:0]            addr_q [2];
  logic [DATA_WIDTH-1:0] data_q [2];
  logic [1:0]            cnt_q, cnt_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [3:0]            starve_q, starve_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [4:0]            rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic       ll_cand, wb_cand, starve_hit, grant_ll, grant_wb, push, pop;
  logic [1:0] slot_vld;

  assign ll_ready   = (cnt_q < 2'd2);
  assign ll_cand    = (cnt_q != 2'd0);
  assign wb_cand    = wb_valid && (wb_waddr != 5'd0);
  assign starve_hit = ll_cand && (starve_q == LIMIT);
  // Reset forces the WB handshake open so the pipeline never stalls on a dead arbiter.
  assign wb_ready   = !sys_rst || !starve_hit;
  assign grant_ll   = ll_cand && (!wb_cand || starve_hit);
  assign grant_wb   = wb_cand && !grant_ll;
  assign push       = ll_valid && ll_ready && (ll_waddr != 5'd0);
  assign pop        = grant_ll;

  always_comb begin
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
    rd_ptr_d   = pop  ? !rd_ptr_q : rd_ptr_q;
    wr_ptr_d   = push ? !wr_ptr_q : wr_ptr_q;
    starve_d   = 4'd0;
    if (ll_cand && grant_wb) begin
      starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
    end
    rf_wen_d   = grant_ll || grant_wb;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_ll) begin
      rf_waddr_d = addr_q[rd_ptr_q];
      rf_wdata_d = data_q[rd_ptr_q];
    end else if (grant_wb) begin
      rf_waddr_d = wb_waddr;
      rf_wdata_d = wb_wdata;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      cnt_q      <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      starve_q   <= 4'd0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      starve_q   <= starve_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Payload slots are qualified by occupancy, so they need no reset.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= ll_waddr;
      data_q[wr_ptr_q] <= ll_wdata;
    end
  end

  assign slot_vld[0] = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !rd_ptr_q);
  assign slot_vld[1] = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && rd_ptr_q);

  always_comb begin
    ll_busy_mask = 32'd0;
    for (int i = 0; i < 2; i++) begin
      if (slot_vld[i]) ll_busy_mask[addr_q[i]] = 1'b1;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule
